cnn_upsampling_nn_stream: RTL and testbench

//  Streaming nearest-neighbour upsampler, integer factor SCALE, for the DeepLabV3+ decoder path.

---
 rtl/cnn_upsampling_nn_stream.sv | 166 ++++++++++++++++
 tb/tb_cnn_upsampling_nn_stream.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_upsampling_nn_stream.sv
// Streaming nearest-neighbour upsampler (factor SCALE) using ping-pong row buffers.
// Optional UPSAMPLING_ZERO_FILL_EN adds mode_zero for zero-insertion instead of replication.
module cnn_upsampling_nn_stream #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned IMAGE_WIDTH  = 16,
  parameter int unsigned IMAGE_HEIGHT = 16,
  parameter int unsigned CHANNEL_NUM  = 256,
  parameter int unsigned SCALE        = 4,
  parameter int unsigned ADDR_WIDTH   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef UPSAMPLING_ZERO_FILL_EN
  input  logic                  mode_zero,
`endif
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  last_out
);

  localparam int unsigned REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  localparam logic [ADDR_WIDTH-1:0] COL_MAX = ADDR_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [REP_W-1:0]      REP_MAX = REP_W'(SCALE - 1);
  localparam logic [ROW_W-1:0]      ROW_MAX = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [CH_W-1:0]       CH_MAX  = CH_W'(CHANNEL_NUM - 1);

  logic [DATA_WIDTH-1:0] bank_q [2][IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] bank_d [2][IMAGE_WIDTH];
  logic [ADDR_WIDTH-1:0] wcol_q, wcol_d, ocol_q, ocol_d;
  logic [REP_W-1:0]      rep_c_q, rep_c_d, rep_r_q, rep_r_d;
  logic [ROW_W-1:0]      orow_q, orow_d;
  logic [CH_W-1:0]       och_q, och_d;
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
  logic                  valid_out_q, valid_out_d, last_out_q, last_out_d;
  logic                  in_acc, load;
`ifdef UPSAMPLING_ZERO_FILL_EN
  logic                  mode_q, mode_d;
`endif

  assign ready_in  = !reset && !full_q[wr_bank_q];
  assign in_acc    = valid_in && ready_in;
  assign load      = full_q[rd_bank_q] && (!valid_out_q || ready_out);
  assign pxl_out   = pxl_out_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;

  // Next-state for both the write (fill) and read (replicate) sides
  always_comb begin
    bank_d      = bank_q;
    wcol_d      = wcol_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    ocol_d      = ocol_q;
    rep_c_d     = rep_c_q;
    rep_r_d     = rep_r_q;
    orow_d      = orow_q;
    och_d       = och_q;
    pxl_out_d   = pxl_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
`ifdef UPSAMPLING_ZERO_FILL_EN
    // Frame-stable mode: only latched while idle at the start of a frame
    mode_d = (och_q == '0 && orow_q == '0 && !valid_out_q) ? mode_zero : mode_q;
`endif

    if (in_acc) begin
      bank_d[wr_bank_q][wcol_q] = pxl_in;
      if (wcol_q == COL_MAX) begin
        wcol_d            = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wcol_d = wcol_q + ADDR_WIDTH'(1);
      end
    end

    if (load) begin
      pxl_out_d = bank_q[rd_bank_q][ocol_q];
`ifdef UPSAMPLING_ZERO_FILL_EN
      if (mode_d && (rep_c_q != '0 || rep_r_q != '0)) pxl_out_d = '0;
`endif
      valid_out_d = 1'b1;
      last_out_d  = (orow_q == ROW_MAX) && (rep_r_q == REP_MAX) &&
                    (ocol_q == COL_MAX) && (rep_c_q == REP_MAX);
      if (rep_c_q != REP_MAX) begin
        rep_c_d = rep_c_q + REP_W'(1);
      end else begin
        rep_c_d = '0;
        if (ocol_q != COL_MAX) begin
          ocol_d = ocol_q + ADDR_WIDTH'(1);
        end else begin
          ocol_d = '0;
          if (rep_r_q != REP_MAX) begin
            rep_r_d = rep_r_q + REP_W'(1);
          end else begin
            // Row fully replicated: release its bank to the writer
            rep_r_d           = '0;
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            if (orow_q != ROW_MAX) begin
              orow_d = orow_q + ROW_W'(1);
            end else begin
              orow_d = '0;
              och_d  = (och_q == CH_MAX) ? '0 : och_q + CH_W'(1);
            end
          end
        end
      end
    end else if (valid_out_q && ready_out) begin
      valid_out_d = 1'b0;
      last_out_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcol_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      ocol_q      <= '0;
      rep_c_q     <= '0;
      rep_r_q     <= '0;
      orow_q      <= '0;
      och_q       <= '0;
      pxl_out_q   <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
`ifdef UPSAMPLING_ZERO_FILL_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      wcol_q      <= wcol_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      ocol_q      <= ocol_d;
      rep_c_q     <= rep_c_d;
      rep_r_q     <= rep_r_d;
      orow_q      <= orow_d;
      och_q       <= och_d;
      pxl_out_q   <= pxl_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
`ifdef UPSAMPLING_ZERO_FILL_EN
      mode_q      <= mode_d;
`endif
    end
  end

  // Row storage carries no reset; the full flags gate all reads
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule

// File: tb/tb_cnn_upsampling_nn_stream.sv
// Self-checking bench for cnn_upsampling_nn_stream (W=2, H=2, C=2, SCALE=2).
// Define UPSAMPLING_ZERO_FILL_EN to also exercise zero-insertion mode.
module tb_cnn_upsampling_nn_stream;

  localparam int W = 2, H = 2, C = 2, S = 2, DW = 16;
  localparam int BEATS = W * S * S;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1, valid_in = 1'b0, ready_out = 1'b0, zm = 1'b0;
  logic ready_in, valid_out, last_out;
  logic [DW-1:0] pxl_in = '0, pxl_out;

  int checks = 0, failures = 0, cyc = 0;
  exp_t exp_q[$];
  logic [DW-1:0] rowbuf[$];
  int plane_row = 0, n_acc = 0, n_deliv = 0, n_last = 0, first_valid = -1;
  int acc_cyc[0:127], deliv_cyc[0:127];
  logic [DW-1:0] dlog[0:127];
  logic llog[0:127];
  logic rst_applied = 1'b0, hold_prev = 1'b0, hl = 1'b0;
  logic [DW-1:0] hp = '0;
  bit ro_rand = 1'b0, ro_force = 1'b0;

  int exp1[16] = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4};
  int exp5[8]  = '{9,9,8,8,9,9,8,8};
  int exp6[16] = '{1,0,2,0,0,0,0,0,3,0,4,0,0,0,0,0};

  cnn_upsampling_nn_stream #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CHANNEL_NUM(C), .SCALE(S)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef UPSAMPLING_ZERO_FILL_EN
    .mode_zero(zm),
`endif
    .valid_in(valid_in),
    .ready_in(ready_in),
    .pxl_in(pxl_in),
    .pxl_out(pxl_out),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .last_out(last_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_applied <= reset;
  end

  always begin
    @(posedge clk);
    #2;
    ready_out = ro_rand ? ($urandom_range(0, 3) != 0) : ro_force;
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference model and per-cycle compare
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (rst_applied) begin
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_last_out", int'(last_out), 0);
        chk("rst_pxl_out", int'(pxl_out), 0);
        chk("rst_ready_in", int'(ready_in), 0);
      end
      exp_q.delete();
      rowbuf.delete();
      plane_row = 0; n_acc = 0; n_deliv = 0; n_last = 0; first_valid = -1;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", int'(valid_out), 1);
        chk("hold_pxl", int'(pxl_out), int'(hp));
        chk("hold_last", int'(last_out), int'(hl));
      end
      if (valid_out && first_valid < 0) first_valid = cyc;
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_pxl", int'(pxl_out), int'(e.d));
          chk("beat_last", int'(last_out), int'(e.l));
        end
        if (n_deliv < 128) begin
          dlog[n_deliv]      = pxl_out;
          llog[n_deliv]      = last_out;
          deliv_cyc[n_deliv] = cyc;
        end
        n_deliv++;
        if (last_out) n_last++;
      end
      if (exp_q.size() == 0) chk("ready_when_empty", int'(ready_in), 1);
      if (exp_q.size() >= BEATS + 2) chk("ready_when_both_full", int'(ready_in), 0);
      hold_prev = valid_out && !ready_out;
      hp = pxl_out;
      hl = last_out;
      if (valid_in && ready_in) begin
        if (n_acc < 128) acc_cyc[n_acc] = cyc;
        n_acc++;
        rowbuf.push_back(pxl_in);
        if (rowbuf.size() == W) begin
          for (int rr = 0; rr < S; rr++)
            for (int c = 0; c < W; c++)
              for (int rc = 0; rc < S; rc++) begin
                e.d = (zm && (rr != 0 || rc != 0)) ? '0 : rowbuf[c];
                e.l = (plane_row == H - 1) && (rr == S - 1) && (c == W - 1) && (rc == S - 1);
                exp_q.push_back(e);
              end
          rowbuf.delete();
          plane_row = (plane_row + 1) % H;
        end
      end
    end
  end

  task automatic send(input int v, input bit gaps);
    int t = 0;
    if (gaps) begin
      int g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end
    valid_in = 1'b1;
    pxl_in   = DW'(v);
    do begin
      @(negedge clk);
      t++;
    end while (!ready_in && t < 300);
    if (!ready_in) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_deliv(input int n, input int budget);
    int t = 0;
    while (n_deliv < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_deliv", int'(n_deliv >= n), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Basic replication and first-beat latency
    ro_force = 1'b1;
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    wait_deliv(16, 200);
    for (int i = 0; i < 16; i++) begin
      chk("t1_pxl", int'(dlog[i]), exp1[i]);
      chk("t1_last", int'(llog[i]), (i == 15) ? 1 : 0);
    end
    chk("t1_latency", first_valid - acc_cyc[1], 2);

    // Output stall at beat 5
    do_reset();
    ro_force = 1'b1;
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    wait_deliv(4, 200);
    ro_force = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t2_stall_valid", int'(valid_out), 1);
      chk("t2_stall_pxl", int'(pxl_out), 1);
      chk("t2_stall_last", int'(last_out), 0);
    end
    repeat (2) @(posedge clk);
    #1 ro_force = 1'b1;
    wait_deliv(16, 200);
    for (int i = 0; i < 16; i++) chk("t2_pxl", int'(dlog[i]), exp1[i]);
    chk("t2_count", n_deliv, 16);

    // Two channel planes
    do_reset();
    ro_force = 1'b1;
    for (int i = 1; i <= 8; i++) send(i, 1'b0);
    wait_deliv(32, 300);
    chk("t4_p2_0", int'(dlog[16]), 5);
    chk("t4_p2_1", int'(dlog[17]), 5);
    chk("t4_p2_2", int'(dlog[18]), 6);
    chk("t4_p2_3", int'(dlog[19]), 6);
    chk("t4_last16", int'(llog[15]), 1);
    chk("t4_last32", int'(llog[31]), 1);
    chk("t4_nlast", n_last, 2);

    // Backpressure: both banks full, input stalls until first row drains
    do_reset();
    ro_force = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    valid_in = 1'b1;
    pxl_in   = DW'(5);
    repeat (4) begin
      @(negedge clk);
      chk("t3_ready_blocked", int'(ready_in), 0);
    end
    chk("t3_acc_count", n_acc, 4);
    @(posedge clk);
    #1 ro_force = 1'b1;
    t = 0;
    while (n_acc < 5 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    valid_in = 1'b0;
    chk("t3_fifth_accepted", int'(n_acc == 5), 1);
    chk("t3_release_timing", int'((acc_cyc[4] - deliv_cyc[7]) inside {0, 1}), 1);
    ro_rand = 1'b1;
    for (int i = 6; i <= 8; i++) send(i, 1'b1);
    wait_deliv(32, 2000);
    chk("t3_drained", exp_q.size(), 0);
    ro_rand = 1'b0;

    // Reset mid-row discards partial data
    do_reset();
    ro_force = 1'b1;
    send(7, 1'b0);
    do_reset();
    send(9, 1'b0); send(8, 1'b0); send(7, 1'b0); send(6, 1'b0);
    wait_deliv(16, 200);
    for (int i = 0; i < 8; i++) chk("t5_pxl", int'(dlog[i]), exp5[i]);

    // Randomized multi-frame traffic
    do_reset();
    ro_rand = 1'b1;
    for (int i = 0; i < 3 * C * H * W; i++) send(int'($urandom_range(0, 65535)), 1'b1);
    wait_deliv(3 * C * H * W * S * S, 4000);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_nlast", n_last, 3 * C);
    ro_rand = 1'b0;

`ifdef UPSAMPLING_ZERO_FILL_EN
    // Zero-insertion mode
    @(posedge clk);
    #1 reset = 1'b1;
    zm = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ro_force = 1'b1;
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    wait_deliv(16, 200);
    for (int i = 0; i < 16; i++) chk("t6_pxl", int'(dlog[i]), exp6[i]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
